// File: rtl/alarm_clock_core.sv
// alarm_clock_core: BCD time-of-day clock with a small alarm table, a ring/snooze state
// machine and an hourly LED chime.
//
// Ports
//   Clk, RST            system clock, synchronous active-high reset
//   EN                  timekeeping enable (prescaler holds while low)
//   Mode                display mode: 0 = 12 h, 1 = 24 h
//   Add_Hour, Add_Min   single-cycle set pulses, act regardless of EN
//   Alarm_Wr/Idx/Hour/Min/En   alarm table write port (BCD, 24 h)
//   Snooze, Stop        single-cycle ring controls
//   Hours/Minutes/Seconds/APM  BCD display, combinational from registered state
//   Ringing, Ring_Idx   ring status and index of the entry that rang last
//   LedSharp            hourly chime LED, blinks N times for 12 h hour N
module alarm_clock_core #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MIN   = 1
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       EN,
    input  logic       Mode,
    input  logic       Add_Hour,
    input  logic       Add_Min,
    input  logic       Alarm_Wr,
    input  logic [3:0] Alarm_Idx,
    input  logic [7:0] Alarm_Hour,
    input  logic [7:0] Alarm_Min,
    input  logic       Alarm_En,
    input  logic       Snooze,
    input  logic       Stop,
    output logic [7:0] Hours,
    output logic [7:0] Minutes,
    output logic [7:0] Seconds,
    output logic       APM,
    output logic       Ringing,
    output logic [3:0] Ring_Idx,
    output logic       LedSharp
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [5:0] CNT_RING = 6'(RING_MIN);
    localparam logic [5:0] CNT_SNZ  = 6'(SNOOZE_MIN);

    typedef enum logic [1:0] {StIdle, StRing, StSnooze} ring_state_e;

    // BCD increment with wrap to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    hour_q, hour_d;
    logic          chime_q, chime_d;

    logic [7:0]    al_hour_q [NUM_ALARMS];
    logic [7:0]    al_min_q  [NUM_ALARMS];
    logic          al_en_q   [NUM_ALARMS];

    ring_state_e   state_q, state_d;
    logic [5:0]    ring_cnt_q, ring_cnt_d;
    logic [5:0]    snz_cnt_q, snz_cnt_d;
    logic [3:0]    ring_idx_q, ring_idx_d;

    logic          tick;
    logic          min_bnd;
    logic          hour_bnd;
    logic          wr_ok;
    logic          match_any;
    logic          match_hit;
    logic [3:0]    match_idx;
    logic          kill;

    // ------------------------------------------------------------------
    // Prescaler and time-of-day next state
    // ------------------------------------------------------------------
    always_comb begin
        tick     = EN && (pre_q == PRE_MAX);
        pre_d    = pre_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        min_bnd  = 1'b0;
        hour_bnd = 1'b0;

        if (EN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end

        if (tick) begin
            sec_d   = bcd_inc(sec_q, 8'h59);
            min_bnd = (sec_q == 8'h59);
        end

        // A set pulse owns its field for the cycle; the tick carry into it is dropped.
        if (Add_Min) begin
            min_d = bcd_inc(min_q, 8'h59);
        end else if (min_bnd) begin
            min_d    = bcd_inc(min_q, 8'h59);
            hour_bnd = (min_q == 8'h59);
        end

        if (Add_Hour || hour_bnd) begin
            hour_d = bcd_inc(hour_q, 8'h23);
        end
    end

    // ------------------------------------------------------------------
    // Alarm table
    // ------------------------------------------------------------------
    always_comb begin
        wr_ok = Alarm_Wr && (32'(Alarm_Idx) < NUM_ALARMS) &&
                bcd_ok(Alarm_Hour, 8'h23) && bcd_ok(Alarm_Min, 8'h59);
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                al_hour_q[i] <= 8'h00;
                al_min_q[i]  <= 8'h00;
                al_en_q[i]   <= 1'b0;
            end
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                if (Alarm_Idx == 4'(i)) begin
                    al_hour_q[i] <= Alarm_Hour;
                    al_min_q[i]  <= Alarm_Min;
                    al_en_q[i]   <= Alarm_En;
                end
            end
        end
    end

    // Compare against the time being entered at this edge; scan downwards so the
    // lowest matching index is the one left standing.
    always_comb begin
        match_any = 1'b0;
        match_idx = 4'd0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (al_en_q[i] && (al_hour_q[i] == hour_d) && (al_min_q[i] == min_d)) begin
                match_any = 1'b1;
                match_idx = 4'(i);
            end
        end
        match_hit = min_bnd && match_any;
        kill      = wr_ok && !Alarm_En && (Alarm_Idx == ring_idx_q);
    end

    // ------------------------------------------------------------------
    // Ring state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        ring_idx_d = ring_idx_q;

        unique case (state_q)
            StIdle: begin
                if (match_hit) begin
                    state_d    = StRing;
                    ring_idx_d = match_idx;
                    ring_cnt_d = CNT_RING;
                end
            end
            StRing: begin
                if (Stop || kill) begin
                    state_d = StIdle;
                end else if (Snooze) begin
                    state_d   = StSnooze;
                    snz_cnt_d = CNT_SNZ;
                end else if (min_bnd) begin
                    ring_cnt_d = ring_cnt_q - 6'd1;
                    if (ring_cnt_d == 6'd0) begin
                        state_d = StIdle;
                    end
                end
            end
            StSnooze: begin
                if (Stop || kill) begin
                    state_d = StIdle;
                end else if (min_bnd) begin
                    snz_cnt_d = snz_cnt_q - 6'd1;
                    if (snz_cnt_d == 6'd0) begin
                        state_d    = StRing;
                        ring_cnt_d = CNT_RING;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Chime arm: set on the hour, cleared by any manual set or once minutes leave 00
    // ------------------------------------------------------------------
    always_comb begin
        chime_d = chime_q;
        if (Add_Hour || Add_Min) begin
            chime_d = 1'b0;
        end else if (hour_bnd) begin
            chime_d = 1'b1;
        end else if (min_d != 8'h00) begin
            chime_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (RST) begin
            pre_q      <= '0;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hour_q     <= 8'h00;
            chime_q    <= 1'b0;
            state_q    <= StIdle;
            ring_cnt_q <= 6'd0;
            snz_cnt_q  <= 6'd0;
            ring_idx_q <= 4'd0;
        end else begin
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            chime_q    <= chime_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ring_idx_q <= ring_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    logic [4:0] hour_bin;
    logic [3:0] h12;
    logic [7:0] h12_bcd;
    logic [5:0] sec_bin;

    always_comb begin
        hour_bin = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
        if (hour_bin == 5'd0) begin
            h12 = 4'd12;
        end else if (hour_bin > 5'd12) begin
            h12 = 4'(hour_bin - 5'd12);
        end else begin
            h12 = hour_bin[3:0];
        end
        h12_bcd = (h12 >= 4'd10) ? {4'd1, h12 - 4'd10} : {4'd0, h12};
        sec_bin = 6'(sec_q[7:4]) * 6'd10 + 6'(sec_q[3:0]);

        Hours    = Mode ? hour_q : h12_bcd;
        Minutes  = min_q;
        Seconds  = sec_q;
        APM      = !Mode && (hour_bin >= 5'd12);
        Ringing  = (state_q == StRing);
        Ring_Idx = ring_idx_q;
        // Even seconds below 2*N give N flashes, one every other second.
        LedSharp = chime_q && !sec_q[0] && (sec_bin < {1'b0, h12, 1'b0});
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Testbench for alarm_clock_core: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model of the clock.
module tb_alarm_clock_core;

    localparam int TD  = 4;
    localparam int NA  = 4;
    localparam int SNZ = 2;
    localparam int RNG = 2;

    logic       Clk = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       Mode = 1'b0;
    logic       Add_Hour = 1'b0;
    logic       Add_Min = 1'b0;
    logic       Alarm_Wr = 1'b0;
    logic [3:0] Alarm_Idx = 4'd0;
    logic [7:0] Alarm_Hour = 8'h00;
    logic [7:0] Alarm_Min = 8'h00;
    logic       Alarm_En = 1'b0;
    logic       Snooze = 1'b0;
    logic       Stop = 1'b0;
    logic [7:0] Hours;
    logic [7:0] Minutes;
    logic [7:0] Seconds;
    logic       APM;
    logic       Ringing;
    logic [3:0] Ring_Idx;
    logic       LedSharp;

    alarm_clock_core #(
        .TICK_DIV  (TD),
        .NUM_ALARMS(NA),
        .SNOOZE_MIN(SNZ),
        .RING_MIN  (RNG)
    ) dut (
        .Clk       (Clk),
        .RST       (RST),
        .EN        (EN),
        .Mode      (Mode),
        .Add_Hour  (Add_Hour),
        .Add_Min   (Add_Min),
        .Alarm_Wr  (Alarm_Wr),
        .Alarm_Idx (Alarm_Idx),
        .Alarm_Hour(Alarm_Hour),
        .Alarm_Min (Alarm_Min),
        .Alarm_En  (Alarm_En),
        .Snooze    (Snooze),
        .Stop      (Stop),
        .Hours     (Hours),
        .Minutes   (Minutes),
        .Seconds   (Seconds),
        .APM       (APM),
        .Ringing   (Ringing),
        .Ring_Idx  (Ring_Idx),
        .LedSharp  (LedSharp)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: time as plain integers, ring status as a mode code
    // (0 quiet, 1 ringing, 2 snoozing) with minutes-left counters.
    int m_pre, m_sec, m_min, m_hour;
    int m_mode, m_left, m_idx;
    bit m_chime;
    int m_ah [NA];
    int m_am [NA];
    bit m_ae [NA];

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int h12f(input int h);
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick, mb, hb, ok, kill, hit;
        int hidx, ns, nm, nh, hh, mm;
        if (RST) begin
            m_pre = 0; m_sec = 0; m_min = 0; m_hour = 0;
            m_mode = 0; m_left = 0; m_idx = 0; m_chime = 0;
            for (int i = 0; i < NA; i++) begin
                m_ah[i] = 0; m_am[i] = 0; m_ae[i] = 0;
            end
            return;
        end
        tick = 0; mb = 0; hb = 0; hit = 0; hidx = 0;
        if (EN) begin
            m_pre = m_pre + 1;
            if (m_pre == TD) begin
                m_pre = 0;
                tick = 1;
            end
        end
        ns = m_sec; nm = m_min; nh = m_hour;
        if (tick) begin
            ns = (m_sec + 1) % 60;
            mb = (m_sec == 59);
        end
        if (Add_Min) nm = (m_min + 1) % 60;
        else if (mb) begin
            nm = (m_min + 1) % 60;
            hb = (m_min == 59);
        end
        if (Add_Hour || hb) nh = (m_hour + 1) % 24;

        hh = int'(Alarm_Hour[7:4]) * 10 + int'(Alarm_Hour[3:0]);
        mm = int'(Alarm_Min[7:4]) * 10 + int'(Alarm_Min[3:0]);
        ok = Alarm_Wr && int'(Alarm_Idx) < NA && Alarm_Hour[7:4] <= 9 && Alarm_Hour[3:0] <= 9 &&
             hh <= 23 && Alarm_Min[7:4] <= 9 && Alarm_Min[3:0] <= 9 && mm <= 59;

        if (mb) begin
            for (int i = 0; i < NA; i++) begin
                if (!hit && m_ae[i] && m_ah[i] == nh && m_am[i] == nm) begin
                    hit = 1;
                    hidx = i;
                end
            end
        end
        kill = ok && !Alarm_En && int'(Alarm_Idx) == m_idx;

        if (m_mode == 0) begin
            if (hit) begin
                m_mode = 1; m_idx = hidx; m_left = RNG;
            end
        end else if (Stop || kill) begin
            m_mode = 0;
        end else if (m_mode == 1 && Snooze) begin
            m_mode = 2; m_left = SNZ;
        end else if (mb) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_mode == 1) m_mode = 0;
                else begin
                    m_mode = 1; m_left = RNG;
                end
            end
        end

        if (Add_Hour || Add_Min) m_chime = 0;
        else if (hb) m_chime = 1;
        else if (nm != 0) m_chime = 0;

        if (ok) begin
            m_ah[int'(Alarm_Idx)] = hh;
            m_am[int'(Alarm_Idx)] = mm;
            m_ae[int'(Alarm_Idx)] = Alarm_En;
        end
        m_sec = ns; m_min = nm; m_hour = nh;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("Hours", int'(Hours), Mode ? bcd(m_hour) : bcd(h12f(m_hour)));
            check("Minutes", int'(Minutes), bcd(m_min));
            check("Seconds", int'(Seconds), bcd(m_sec));
            check("APM", int'(APM), (!Mode && m_hour >= 12) ? 1 : 0);
            check("Ringing", int'(Ringing), (m_mode == 1) ? 1 : 0);
            check("Ring_Idx", int'(Ring_Idx), m_idx);
            check("LedSharp", int'(LedSharp),
                  (m_chime && m_sec % 2 == 0 && m_sec < 2 * h12f(m_hour)) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        #1;
    endtask

    task automatic clr();
        Add_Hour = 0; Add_Min = 0; Alarm_Wr = 0; Snooze = 0; Stop = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_hour(input int n);
        repeat (n) begin
            Add_Hour = 1; step(); Add_Hour = 0;
        end
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            Add_Min = 1; step(); Add_Min = 0;
        end
    endtask

    task automatic wr(input int idx, input logic [7:0] h, input logic [7:0] m, input bit en);
        Alarm_Wr = 1; Alarm_Idx = 4'(idx); Alarm_Hour = h; Alarm_Min = m; Alarm_En = en;
        step();
        Alarm_Wr = 0;
    endtask

    task automatic do_reset();
        RST = 1; EN = 0; clr();
        step(); step();
        RST = 0;
        chk_en = 1;
    endtask

    initial begin
        // Reset state
        do_reset();
        Mode = 0; #1;
        check("rst_hours12", int'(Hours), 'h12);
        check("rst_minutes", int'(Minutes), 'h00);
        check("rst_seconds", int'(Seconds), 'h00);
        check("rst_apm", int'(APM), 0);
        check("rst_ringing", int'(Ringing), 0);
        check("rst_led", int'(LedSharp), 0);
        Mode = 1; #1;
        check("rst_hours24", int'(Hours), 'h00);

        // Set 23:59:00, run one minute across midnight
        pulse_hour(23);
        pulse_min(59);
        check("set_2359_h", int'(Hours), 'h23);
        check("set_2359_m", int'(Minutes), 'h59);
        EN = 1; run(60 * TD); EN = 0;
        Mode = 0; #1;
        check("midnight_h12", int'(Hours), 'h12);
        check("midnight_apm", int'(APM), 0);
        check("midnight_min", int'(Minutes), 'h00);
        check("midnight_sec", int'(Seconds), 'h00);
        check("midnight_led", int'(LedSharp), 1);

        // Hour 13 in both modes
        pulse_hour(13);
        check("h13_12h", int'(Hours), 'h01);
        check("h13_pm", int'(APM), 1);
        check("h13_led_off", int'(LedSharp), 0);
        Mode = 1; #1;
        check("h13_24h", int'(Hours), 'h13);
        check("h13_apm24", int'(APM), 0);

        // Two matching entries, lowest wins; invalid writes leave entry 0 alone
        do_reset();
        Mode = 0;
        wr(0, 8'h07, 8'h30, 1);
        wr(2, 8'h07, 8'h30, 1);
        wr(1, 8'h07, 8'h30, 0);
        wr(0, 8'h24, 8'h30, 0);
        wr(0, 8'h07, 8'h3A, 0);
        wr(0, 8'h1A, 8'h30, 0);
        wr(5, 8'h07, 8'h30, 0);
        pulse_hour(7);
        pulse_min(29);
        EN = 1; run(60 * TD);
        check("ring_0730", int'(Ringing), 1);
        check("ring_idx0", int'(Ring_Idx), 0);
        run(60 * TD);
        check("ring_still", int'(Ringing), 1);
        run(60 * TD);
        check("ring_auto_stop", int'(Ringing), 0);
        check("ring_idx_hold", int'(Ring_Idx), 0);

        // Snooze then re-ring, then Stop+Snooze together
        EN = 0; wr(1, 8'h07, 8'h33, 1); EN = 1;
        run(60 * TD);
        check("ring_0733", int'(Ringing), 1);
        check("ring_idx1", int'(Ring_Idx), 1);
        EN = 0; Snooze = 1; step(); clr();
        check("snooze_quiet", int'(Ringing), 0);
        EN = 1; run(60 * TD);
        check("snooze_1min", int'(Ringing), 0);
        run(60 * TD);
        check("snooze_rering", int'(Ringing), 1);
        EN = 0; Stop = 1; Snooze = 1; step(); clr();
        check("stop_wins", int'(Ringing), 0);
        EN = 1; run(2 * 60 * TD);
        check("stop_idle", int'(Ringing), 0);

        // Disabling the ringing entry silences it
        EN = 0; wr(3, 8'h07, 8'h38, 1); EN = 1;
        run(60 * TD);
        check("ring_idx3", int'(Ring_Idx), 3);
        check("ring_0738", int'(Ringing), 1);
        EN = 0; wr(3, 8'h07, 8'h38, 0);
        check("disable_kill", int'(Ringing), 0);

        // Chime at 03:00
        do_reset();
        Mode = 0;
        pulse_hour(2);
        pulse_min(59);
        EN = 1; run(60 * TD);
        check("chime_s00", int'(LedSharp), 1);
        run(TD);
        check("chime_s01", int'(LedSharp), 0);
        run(TD);
        check("chime_s02", int'(LedSharp), 1);
        run(2 * TD);
        check("chime_s04", int'(LedSharp), 1);
        run(2 * TD);
        check("chime_s06", int'(LedSharp), 0);

        // Add_Min at second 01 cancels the chime
        do_reset();
        pulse_hour(2);
        pulse_min(59);
        EN = 1; run(60 * TD + TD);
        EN = 0; pulse_min(1); EN = 1;
        run(TD);
        check("chime_cancel_s02", int'(LedSharp), 0);
        check("chime_cancel_min", int'(Minutes), 'h01);

        // Randomized phase
        do_reset();
        for (int c = 0; c < 20000; c++) begin
            EN = ($urandom_range(0, 15) != 0);
            Mode = 1'($urandom_range(0, 1));
            Add_Hour = ($urandom_range(0, 199) == 0);
            Add_Min = ($urandom_range(0, 59) == 0);
            Snooze = ($urandom_range(0, 299) == 0);
            Stop = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) begin
                Alarm_Wr = 1;
                Alarm_Idx = 4'($urandom_range(0, 5));
                Alarm_En = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) == 0) begin
                    Alarm_Hour = 8'($urandom_range(0, 255));
                    Alarm_Min = 8'($urandom_range(0, 255));
                end else begin
                    Alarm_Hour = 8'(bcd(m_hour));
                    Alarm_Min = 8'(bcd((m_min + $urandom_range(0, 2)) % 60));
                end
            end
            RST = ($urandom_range(0, 4999) == 0);
            step();
            clr();
            RST = 0;
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_clock_core.md
ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, Clk cycles per second tick.
REQ-002 SHALL have parameter NUM_ALARMS, default 4, number of alarm entries (1..16).
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, minute boundaries spent snoozing (1..60).
REQ-004 SHALL have parameter RING_MIN, default 1, minute boundaries of unanswered ringing before auto-stop (1..60).
REQ-005 SHALL have ports, in this order: Clk in 1 system clock; RST in 1 reset.
REQ-006 SHALL have ports EN in 1 timekeeping enable; Mode in 1 display mode (0 = 12 h, 1 = 24 h).
REQ-007 SHALL have ports Add_Hour in 1 and Add_Min in 1, single-cycle set pulses.
REQ-008 SHALL have ports Alarm_Wr in 1, Alarm_Idx in 4, Alarm_Hour in 8 (BCD, 24 h), Alarm_Min in 8 (BCD), Alarm_En in 1.
REQ-009 SHALL have ports Snooze in 1 and Stop in 1, single-cycle pulses.
REQ-010 SHALL have outputs Hours out 8 BCD, Minutes out 8 BCD, Seconds out 8 BCD, APM out 1 (1 = PM).
REQ-011 SHALL have outputs Ringing out 1, Ring_Idx out 4, LedSharp out 1.
REQ-012 SHALL use the single clock Clk, with RST synchronous and active-high.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 while EN=1, hold while EN=0, and emit a one-cycle tick on the cycle it wraps.
REQ-014 On each tick, seconds SHALL advance 00..59 in BCD; 59->00 is a minute boundary, which advances minutes 00..59.
REQ-015 A minute wrap 59->00 from a minute boundary is an hour boundary, which advances the internal 24 h hour 00..23, with 23->00.
REQ-016 Add_Min SHALL advance minutes by 1 (59->00) with no carry into hours; Add_Hour SHALL advance hours by 1 (23->00); both SHALL act regardless of EN and leave seconds unchanged.
REQ-017 If a set pulse and a tick carry hit the same field in one cycle, the set pulse SHALL win and that carry SHALL be discarded; a set pulse never generates a minute or hour boundary.
REQ-018 In Mode=1, Hours SHALL equal the internal hour and APM=0.
REQ-019 In Mode=0, internal hour 00 SHALL display as 12 with APM=0; 01-11 as 01-11 with APM=0; 12 as 12 with APM=1; 13-23 as 01-11 with APM=1.
REQ-020 Display outputs SHALL be combinational from registered state, with zero latency.
REQ-021 Alarm_Wr SHALL write {Alarm_Hour, Alarm_Min, Alarm_En} into entry Alarm_Idx on the next edge.
REQ-022 A write SHALL be ignored when Alarm_Idx >= NUM_ALARMS, Alarm_Hour > 0x23, Alarm_Min > 0x59, or either field has a BCD nibble > 9.
REQ-023 Match SHALL be evaluated only at a minute boundary, against the new HH:MM of enabled entries; on multiple matches the lowest index wins.
REQ-024 Ring FSM states: IDLE, RING, SNOOZE. IDLE + match -> RING: latch Ring_Idx and load ring counter = RING_MIN.
REQ-025 In RING, Stop -> IDLE; Snooze -> SNOOZE with snooze counter = SNOOZE_MIN.
REQ-026 In RING, the ring counter SHALL decrement at each minute boundary; at 0 -> IDLE.
REQ-027 In SNOOZE, the snooze counter SHALL decrement at each minute boundary; at 0 -> RING with the ring counter reloaded. Stop -> IDLE.
REQ-028 Stop and Snooze in the same cycle: Stop wins. A match in RING or SNOOZE SHALL be ignored.
REQ-029 A write that disables entry Ring_Idx while in RING or SNOOZE SHALL force IDLE.
REQ-030 Ringing SHALL be 1 only in RING; Ring_Idx SHALL hold its last value in IDLE.
REQ-031 Chime SHALL be armed by an hour boundary and disarmed by Add_Hour, Add_Min, or minutes != 00.
REQ-032 While the chime is armed, LedSharp SHALL be 1 exactly when Seconds is even and Seconds < 2*N, N = 12 h display hour (1..12) of the current time.

Reset
REQ-033 RST SHALL set time to 00:00:00 and clear the prescaler, alarm entries (00:00, disabled), FSM (IDLE), counters, chime arm and Ring_Idx.
REQ-034 After reset, outputs SHALL be Hours=0x00 (Mode=1) or 0x12 (Mode=0), APM=0, Ringing=0, LedSharp=0.
REQ-035 RST asserted mid-ring or mid-set SHALL take effect on that edge and override all other inputs.

Verification (TICK_DIV=4)
REQ-036 Reset, Mode=0 -> Hours=0x12, Minutes=0x00, Seconds=0x00, APM=0, Ringing=0.
REQ-037 23 Add_Hour + 59 Add_Min pulses, then 60 ticks -> 00:00:00; Mode=0 shows 0x12 with APM=0.
REQ-038 Hour set to 13, Mode=0 -> Hours=0x01, APM=1; Mode=1 -> Hours=0x13, APM=0.
REQ-039 Entries 0 and 2 both 07:30 enabled, run across 07:29:59 -> Ringing=1, Ring_Idx=0; with no response, IDLE after RING_MIN minute boundaries.
REQ-040 SNOOZE_MIN=2: Snooze while ringing -> Ringing=0, re-ring after 2 minute boundaries; Stop+Snooze in the same cycle -> IDLE.
REQ-041 Tick into 03:00:00 -> LedSharp=1 at seconds 00, 02, 04 only; an Add_Min pulse at second 01 -> LedSharp stays 0.
